// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial input qualifiers and detector outputs.
// The master drives the sample stream and the slave (the detector) drives the results.
interface seq_detect_param_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(LEN + 1);

    logic              x;
    logic              in_valid;
    logic              ovl;
    logic              clr;
    logic              z;
    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill;

    modport master (output x, in_valid, ovl, clr, input  z, cnt, fill);
    modport slave  (input  x, in_valid, ovl, clr, output z, cnt, fill);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a registered one-cycle match pulse,
// a saturating match counter, run-time overlap selection and a synchronous clear.
module seq_detect_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1010,
    parameter int             CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam int                FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [LEN-1:0]    r_hist;
    logic [LEN-1:0]    w_hist_nxt;
    logic [LEN-1:0]    w_hist_shift;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [FILL_W-1:0] w_fill_inc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_z;
    logic              w_z_nxt;
    logic              w_match;

    // Candidate history/fill if the current bit were accepted; the newest bit enters at the LSB.
    always_comb begin
        w_hist_shift = {r_hist[LEN-2:0], bus.x};
        w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
        w_match      = (w_fill_inc == FILL_FULL) && (w_hist_shift == PATTERN);
    end

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_cnt_nxt  = r_cnt;
        w_z_nxt    = 1'b0;
        if (bus.clr) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
            w_cnt_nxt  = '0;
        end else if (bus.in_valid) begin
            w_hist_nxt = w_hist_shift;
            w_fill_nxt = w_fill_inc;
            if (w_match) begin
                w_z_nxt = 1'b1;
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // Non-overlapping mode restarts collection so the next match needs LEN fresh bits.
                if (!bus.ovl) begin
                    w_hist_nxt = '0;
                    w_fill_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_z    <= 1'b0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_cnt  <= w_cnt_nxt;
            r_z    <= w_z_nxt;
        end
    end

    assign bus.z    = r_z;
    assign bus.cnt  = r_cnt;
    assign bus.fill = r_fill;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and random bench for seq_detect_param across four parameter sets sharing one stimulus stream.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic x = 1'b0;
    logic in_valid = 1'b0;
    logic ovl = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.LEN(4), .CNT_W(8)) if_a ();
    seq_detect_param_if #(.LEN(4), .CNT_W(2)) if_b ();
    seq_detect_param_if #(.LEN(3), .CNT_W(8)) if_c ();
    seq_detect_param_if #(.LEN(2), .CNT_W(8)) if_d ();

    assign if_a.x = x; assign if_a.in_valid = in_valid; assign if_a.ovl = ovl; assign if_a.clr = clr;
    assign if_b.x = x; assign if_b.in_valid = in_valid; assign if_b.ovl = ovl; assign if_b.clr = clr;
    assign if_c.x = x; assign if_c.in_valid = in_valid; assign if_c.ovl = ovl; assign if_c.clr = clr;
    assign if_d.x = x; assign if_d.in_valid = in_valid; assign if_d.ovl = ovl; assign if_d.clr = clr;

    seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
    seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (.clk(clk), .rst(rst_n), .bus(if_b));
    seq_detect_param #(.LEN(3), .PATTERN(3'b110),  .CNT_W(8)) dut_c (.clk(clk), .rst(rst_n), .bus(if_c));
    seq_detect_param #(.LEN(2), .PATTERN(2'b11),   .CNT_W(8)) dut_d (.clk(clk), .rst(rst_n), .bus(if_d));

    task automatic step(input logic bx, input logic bv, input logic bo, input logic bc);
        x = bx; in_valid = bv; ovl = bo; clr = bc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] bits;
        logic [3:0] ez;
        bits = 4'b1010;
        ez   = 4'b0001;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (if_a.z !== 1'b0) begin errors++; $display("FAIL reset_z got %0b want 0", if_a.z); end
        checks++; if (if_a.cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", if_a.cnt); end
        checks++; if (if_a.fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", if_a.fill); end
        @(negedge clk); rst_n = 1'b1;
        step(1, 1, 1, 0); step(0, 1, 1, 0); step(1, 1, 1, 0);
        checks++; if (if_a.fill !== 3'd3) begin errors++; $display("FAIL pre_async_fill got %0d want 3", if_a.fill); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if_a.fill !== 3'd0) begin errors++; $display("FAIL async_fill got %0d want 0", if_a.fill); end
        checks++; if (if_a.cnt !== 8'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", if_a.cnt); end
        checks++; if (if_a.z !== 1'b0) begin errors++; $display("FAIL async_z got %0b want 0", if_a.z); end
        @(posedge clk); #1;
        checks++; if (if_a.fill !== 3'd0) begin errors++; $display("FAIL held_reset_fill got %0d want 0", if_a.fill); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i], 1, 1, 0);
            checks++; if (if_a.z !== ez[3-i]) begin errors++; $display("FAIL post_reset_z bit%0d got %0b want %0b", i, if_a.z, ez[3-i]); end
        end
        checks++; if (if_a.cnt !== 8'd1) begin errors++; $display("FAIL post_reset_cnt got %0d want 1", if_a.cnt); end
        step(0, 0, 1, 0);
        checks++; if (if_a.z !== 1'b0) begin errors++; $display("FAIL pulse_end_z got %0b want 0", if_a.z); end
    endtask

    task automatic test_overlap();
        logic [5:0] bits;
        logic [5:0] ez;
        bits = 6'b101010;
        ez   = 6'b000101;
        step(0, 0, 1, 1);
        checks++; if (if_a.cnt !== 8'd0 || if_a.fill !== 3'd0) begin errors++; $display("FAIL clr_state cnt %0d fill %0d want 0 0", if_a.cnt, if_a.fill); end
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i], 1, 1, 0);
            checks++; if (if_a.z !== ez[5-i]) begin errors++; $display("FAIL overlap_z bit%0d got %0b want %0b", i + 1, if_a.z, ez[5-i]); end
        end
        checks++; if (if_a.cnt !== 8'd2) begin errors++; $display("FAIL overlap_cnt got %0d want 2", if_a.cnt); end
        checks++; if (if_a.fill !== 3'd4) begin errors++; $display("FAIL overlap_fill got %0d want 4", if_a.fill); end
    endtask

    task automatic test_nonoverlap();
        logic [5:0] bits;
        logic [5:0] ez;
        bits = 6'b101010;
        ez   = 6'b000100;
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i], 1, 0, 0);
            checks++; if (if_a.z !== ez[5-i]) begin errors++; $display("FAIL nonoverlap_z bit%0d got %0b want %0b", i + 1, if_a.z, ez[5-i]); end
        end
        checks++; if (if_a.cnt !== 8'd1) begin errors++; $display("FAIL nonoverlap_cnt got %0d want 1", if_a.cnt); end
        checks++; if (if_a.fill !== 3'd2) begin errors++; $display("FAIL nonoverlap_fill got %0d want 2", if_a.fill); end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        bits = 4'b1010;
        step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i], 1, 1, 0);
            checks++; if (if_a.z !== (i == 3)) begin errors++; $display("FAIL gap_z bit%0d got %0b want %0b", i + 1, if_a.z, (i == 3)); end
            for (int g = 0; g < 3; g++) begin
                step(1'($urandom), 0, 1, 0);
                checks++; if (if_a.z !== 1'b0) begin errors++; $display("FAIL gap_idle_z bit%0d gap%0d got %0b want 0", i + 1, g, if_a.z); end
            end
        end
        checks++; if (if_a.cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt got %0d want 1", if_a.cnt); end
        checks++; if (if_a.fill !== 3'd4) begin errors++; $display("FAIL gap_fill got %0d want 4", if_a.fill); end
    endtask

    task automatic test_saturation_clear();
        logic [1:0] ecnt;
        step(0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            ecnt = (k < 3) ? 2'(k + 1) : 2'd3;
            step(1, 1, 1, 0);
            checks++; if (if_b.z !== 1'b0) begin errors++; $display("FAIL sat_z_one match%0d got %0b want 0", k + 1, if_b.z); end
            step(0, 1, 1, 0);
            if (k > 0) begin
                checks++; if (if_b.z !== 1'b1) begin errors++; $display("FAIL sat_z match%0d got %0b want 1", k + 1, if_b.z); end
            end
            checks++; if (if_b.cnt !== (k == 0 ? 2'd0 : ecnt - 2'(k < 3 ? 1 : 0))) begin
                errors++; $display("FAIL sat_cnt step%0d got %0d want %0d", k + 1, if_b.cnt, (k == 0 ? 2'd0 : ecnt - 2'(k < 3 ? 1 : 0)));
            end
        end
        // the stream 1,0,1,0,... matches first on the 4th bit, then every 2 bits after
        step(1, 1, 1, 0); step(0, 1, 1, 0);
        checks++; if (if_b.z !== 1'b1 || if_b.cnt !== 2'd3) begin errors++; $display("FAIL sat_hold z %0b cnt %0d want 1 3", if_b.z, if_b.cnt); end
        step(1, 1, 1, 1);
        checks++; if (if_b.cnt !== 2'd0 || if_b.fill !== 3'd0 || if_b.z !== 1'b0) begin
            errors++; $display("FAIL clr_valid cnt %0d fill %0d z %0b want 0 0 0", if_b.cnt, if_b.fill, if_b.z);
        end
        step(0, 1, 1, 0);
        checks++; if (if_b.fill !== 3'd1) begin errors++; $display("FAIL clr_discard_fill got %0d want 1", if_b.fill); end
        step(1, 1, 1, 0); step(0, 1, 1, 0);
        checks++; if (if_b.z !== 1'b0 || if_b.fill !== 3'd3) begin errors++; $display("FAIL clr_discard_z z %0b fill %0d want 0 3", if_b.z, if_b.fill); end
    endtask

    task automatic test_param_len3();
        logic [6:0] bits;
        logic [6:0] ez;
        bits = 7'b1110110;
        ez   = 7'b0001001;
        step(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) begin
            step(bits[6-i], 1, 1, 0);
            checks++; if (if_c.z !== ez[6-i]) begin errors++; $display("FAIL len3_z bit%0d got %0b want %0b", i + 1, if_c.z, ez[6-i]); end
        end
        checks++; if (if_c.cnt !== 8'd2) begin errors++; $display("FAIL len3_cnt got %0d want 2", if_c.cnt); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ez;
        ez = 3'b011;
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0);
            checks++; if (if_d.z !== ez[2-i]) begin errors++; $display("FAIL b2b_z bit%0d got %0b want %0b", i + 1, if_d.z, ez[2-i]); end
        end
        checks++; if (if_d.cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", if_d.cnt); end
        step(1, 1, 0, 0);
        checks++; if (if_d.z !== 1'b1 || if_d.fill !== 2'd0) begin errors++; $display("FAIL b2b_ovl_off z %0b fill %0d want 1 0", if_d.z, if_d.fill); end
        step(1, 1, 0, 0);
        checks++; if (if_d.z !== 1'b0) begin errors++; $display("FAIL b2b_fresh_z got %0b want 0", if_d.z); end
    endtask

    task automatic test_random();
        logic [3:0] m_hist;
        logic [3:0] h;
        int         m_fill;
        int         m_cnt;
        int         f;
        logic       m_z;
        logic       bx, bv, bo, bc;
        step(0, 0, 0, 1);
        m_hist = '0; m_fill = 0; m_cnt = 0; m_z = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bx = 1'($urandom);
            bv = ($urandom_range(0, 9) < 7);
            bo = 1'($urandom);
            bc = ($urandom_range(0, 99) < 2);
            step(bx, bv, bo, bc);
            if (bc) begin
                m_hist = '0; m_fill = 0; m_cnt = 0; m_z = 1'b0;
            end else if (!bv) begin
                m_z = 1'b0;
            end else begin
                h = {m_hist[2:0], bx};
                f = (m_fill < 4) ? m_fill + 1 : 4;
                if (f == 4 && h == 4'b1010) begin
                    m_z = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    m_hist = bo ? h : 4'b0;
                    m_fill = bo ? f : 0;
                end else begin
                    m_z = 1'b0; m_hist = h; m_fill = f;
                end
            end
            checks++;
            if (if_a.z !== m_z || if_a.cnt !== 8'(m_cnt) || if_a.fill !== 3'(m_fill)) begin
                errors++;
                $display("FAIL random cyc%0d z/cnt/fill got %0b/%0d/%0d want %0b/%0d/%0d", n, if_a.z, if_a.cnt, if_a.fill, m_z, m_cnt, m_fill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gapped();
        test_saturation_clear();
        test_param_len3();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
